// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shifter.
//   OP_*      : operation encodings presented on the op port
//   state_e   : FSM state encoding used by iter_shifter
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage : shift_pkg

// File: rtl/shift_step.sv
// One combinational shift step of the iterative shifter.
// Ports:
//   op    in  2        operation (OP_SLL / OP_SRL / OP_SRA / OP_ROL)
//   sign  in  1        fill bit for arithmetic right shift
//   x     in  WIDTH    value to shift
//   n     in  SHAMT_W  bits to shift this step (the caller keeps n <= STEP)
//   y     out WIDTH    shifted value
module shift_step
    import shift_pkg::*;
#(
    parameter  int WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [1:0]         op,
    input  logic               sign,
    input  logic [WIDTH-1:0]   x,
    input  logic [SHAMT_W-1:0] n,
    output logic [WIDTH-1:0]   y
);

    // Double-width scratch: the upper half carries the sign fill for SRA,
    // and a duplicated copy of x lets ROL be expressed as a plain left shift.
    logic [2*WIDTH-1:0] dbl_s;

    // Select the shift flavour for this step.
    always_comb begin
        dbl_s = '0;
        y     = x;
        case (op)
            OP_SLL: begin
                y = x << n;
            end
            OP_SRL: begin
                y = x >> n;
            end
            OP_SRA: begin
                dbl_s = {{WIDTH{sign}}, x} >> n;
                y     = dbl_s[WIDTH-1:0];
            end
            OP_ROL: begin
                dbl_s = {x, x} << n;
                y     = dbl_s[2*WIDTH-1:WIDTH];
            end
            default: begin
                y = x;
            end
        endcase
    end

endmodule : shift_step

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: shifts up to STEP bits per clock with a start/busy/done
// handshake. Supports SLL, SRL, SRA and ROL by a run-time amount.
// Ports:
//   clk    in   1        rising-edge clock
//   rst_n  in   1        asynchronous active-low reset
//   start  in   1        request, accepted when not busy
//   op     in   2        operation, sampled on accept
//   a      in   WIDTH    operand, sampled on accept
//   shamt  in   SHAMT_W  shift amount, sampled on accept
//   busy   out  1        high while shifting
//   done   out  1        one-cycle pulse marking c valid
//   c      out  WIDTH    result, held until the next accepted start completes
module iter_shifter
    import shift_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int STEP    = 1,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   c
);

    localparam logic [SHAMT_W-1:0] STEP_N = SHAMT_W'(STEP);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     work_q,  work_d;
    logic [SHAMT_W-1:0]   rem_q,   rem_d;
    logic [1:0]           op_q,    op_d;
    logic                 sign_q,  sign_d;
    logic [WIDTH-1:0]     c_q,     c_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;

    logic [SHAMT_W-1:0]   step_n_s;
    logic [WIDTH-1:0]     step_y_s;

    // Bits shifted this cycle: the full STEP unless fewer remain.
    assign step_n_s = (rem_q > STEP_N) ? STEP_N : rem_q;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op   (op_q),
        .sign (sign_q),
        .x    (work_q),
        .n    (step_n_s),
        .y    (step_y_s)
    );

    // Next-state logic for the handshake FSM and the datapath registers.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        op_d    = op_q;
        sign_d  = sign_q;
        c_d     = c_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    work_d = a;
                    rem_d  = shamt;
                    op_d   = op;
                    sign_d = a[WIDTH-1];
                    if (shamt == '0) begin
                        // Nothing to shift: the operand is the result.
                        state_d = ST_DONE;
                        c_d     = a;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_d = step_y_s;
                rem_d  = rem_q - step_n_s;
                if (rem_d == '0) begin
                    // c only ever sees the finished value.
                    state_d = ST_DONE;
                    c_d     = step_y_s;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; reset discards any shift in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            op_q    <= 2'b00;
            sign_q  <= 1'b0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign c    = c_q;

endmodule : iter_shifter
